// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter and its prescaler.
package counter_pkg;

  localparam logic C_DIR_UP = 1'b1;
  localparam logic C_DIR_DN = 1'b0;

  localparam int C_MODE_WRAP = 0;
  localparam int C_MODE_SAT  = 1;

  // Prescaler register width: at least one bit even when no division is requested.
  function automatic int prescale_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_updown_mod_clk_en_prescaler.sv
// Enable-gated prescaler: emits a count event every G_DIV enabled cycles.
module clk_en_prescaler
  import counter_pkg::*;
#(
  parameter int G_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic evt
);

  localparam int              C_PW   = prescale_width(G_DIV);
  localparam logic [C_PW-1:0] C_LAST = C_PW'(G_DIV - 1);

  logic [C_PW-1:0] cnt_r;
  logic [C_PW-1:0] cnt_nxt_s;
  logic            wrap_s;

  // evt is same-cycle so the counter register can act on it at this edge.
  assign wrap_s = (cnt_r == C_LAST);
  assign evt    = en & wrap_s;

  // Next prescaler phase: clear, advance while enabled, or hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = '0;
    end else if (en) begin
      if (wrap_s) begin
        cnt_nxt_s = '0;
      end else begin
        cnt_nxt_s = cnt_r + C_PW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Prescaler phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// General-purpose up/down counter with runtime modulus, wrap/saturate boundary,
// load, prescaled enable, registered terminal-count pulse and sticky overflow.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int G_WIDTH    = 4,
  parameter int G_PRESCALE = 1,
  parameter int G_MODE_SAT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               up_dn,
  input  logic               load,
  input  logic [G_WIDTH-1:0] load_val,
  input  logic [G_WIDTH-1:0] limit,
  input  logic               clr_ovf,
  output logic [G_WIDTH-1:0] out,
  output logic               tc,
  output logic               ovf
);

  localparam logic C_SAT = (G_MODE_SAT == C_MODE_SAT);

  logic [G_WIDTH-1:0] count_r;
  logic [G_WIDTH-1:0] count_nxt_s;
  logic               tc_r;
  logic               ovf_r;
  logic               ovf_nxt_s;
  logic               bnd_s;
  logic               evt_s;

  clk_en_prescaler #(
    .G_DIV (G_PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (en),
    .evt   (evt_s)
  );

  // Next count and boundary detection; load beats a count event in the same cycle.
  always_comb begin
    count_nxt_s = count_r;
    bnd_s       = 1'b0;
    if (load) begin
      if (load_val <= limit) begin
        count_nxt_s = load_val;
      end else begin
        count_nxt_s = limit;
      end
    end else if (evt_s) begin
      if (up_dn == C_DIR_UP) begin
        if (count_r < limit) begin
          count_nxt_s = count_r + G_WIDTH'(1);
        end else begin
          bnd_s       = 1'b1;
          count_nxt_s = C_SAT ? limit : '0;
        end
      end else begin
        // A count above a freshly lowered limit is pulled back without flagging a boundary.
        if (count_r > limit) begin
          count_nxt_s = limit;
        end else if (count_r != '0) begin
          count_nxt_s = count_r - G_WIDTH'(1);
        end else begin
          bnd_s       = 1'b1;
          count_nxt_s = C_SAT ? '0 : limit;
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Sticky overflow: a boundary in the same cycle beats clr_ovf.
  always_comb begin
    ovf_nxt_s = ovf_r;
    if (bnd_s) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Count, terminal-count and overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      tc_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tc_r    <= bnd_s;
      ovf_r   <= ovf_nxt_s;
    end
  end

  assign out = count_r;
  assign tc  = tc_r;
  assign ovf = ovf_r;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench: three counter variants (wrap, saturate, prescale-by-3) share stimulus.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] limit = 4'd9;
  logic       clr_ovf = 1'b0;

  logic [3:0] w_out, s_out, p_out;
  logic       w_tc, s_tc, p_tc;
  logic       w_ovf, s_ovf, p_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_updown_mod #(.G_WIDTH(4), .G_PRESCALE(1), .G_MODE_SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .limit(limit), .clr_ovf(clr_ovf), .out(w_out), .tc(w_tc), .ovf(w_ovf));

  counter_updown_mod #(.G_WIDTH(4), .G_PRESCALE(1), .G_MODE_SAT(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .limit(limit), .clr_ovf(clr_ovf), .out(s_out), .tc(s_tc), .ovf(s_ovf));

  counter_updown_mod #(.G_WIDTH(4), .G_PRESCALE(3), .G_MODE_SAT(0)) u_pre (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .limit(limit), .clr_ovf(clr_ovf), .out(p_out), .tc(p_tc), .ovf(p_ovf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; en = 1'b0; load = 1'b0; clr_ovf = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd5; up_dn = 1'b1; limit = 4'd9;
    tick();
    n_checks++;
    if (w_out !== 4'd0 || w_tc !== 1'b0 || w_ovf !== 1'b0) begin
      $display("FAIL reset_wrap out=%0d tc=%b ovf=%b expected 0 0 0", w_out, w_tc, w_ovf);
      n_fail++;
    end
    n_checks++;
    if (s_out !== 4'd0 || p_out !== 4'd0 || s_tc !== 1'b0 || p_ovf !== 1'b0) begin
      $display("FAIL reset_others s_out=%0d p_out=%0d s_tc=%b p_ovf=%b expected 0", s_out, p_out, s_tc, p_ovf);
      n_fail++;
    end
    reset = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_wrap_up;
    logic [3:0] exp_out [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic       exp_tc;
    logic       exp_ovf;
    limit = 4'd9; up_dn = 1'b1; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_tc  = (i == 9);
      exp_ovf = (i >= 9);
      n_checks++;
      if (w_out !== exp_out[i] || w_tc !== exp_tc || w_ovf !== exp_ovf) begin
        $display("FAIL wrap_up[%0d] out=%0d tc=%b ovf=%b expected %0d %b %b",
                 i, w_out, w_tc, w_ovf, exp_out[i], exp_tc, exp_ovf);
        n_fail++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_down;
    logic [3:0] exp_out [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
    logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    // ovf is still set from the previous wrap; load must not clear it
    load = 1'b1; load_val = 4'd2; en = 1'b1; up_dn = 1'b0; limit = 4'd9;
    tick();
    load = 1'b0;
    n_checks++;
    if (w_out !== 4'd2 || w_tc !== 1'b0 || w_ovf !== 1'b1) begin
      $display("FAIL load_down_load out=%0d tc=%b ovf=%b expected 2 0 1", w_out, w_tc, w_ovf);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (w_out !== exp_out[i] || w_tc !== exp_tc[i] || w_ovf !== 1'b1) begin
        $display("FAIL load_down[%0d] out=%0d tc=%b ovf=%b expected %0d %b 1",
                 i, w_out, w_tc, w_ovf, exp_out[i], exp_tc[i]);
        n_fail++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate;
    logic [3:0] exp_out [4] = '{4'd14, 4'd15, 4'd15, 4'd15};
    logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    limit = 4'd15; load = 1'b1; load_val = 4'd13; en = 1'b1; up_dn = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (s_out !== 4'd13 || s_tc !== 1'b0) begin
      $display("FAIL sat_load out=%0d tc=%b expected 13 0", s_out, s_tc);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (s_out !== exp_out[i] || s_tc !== exp_tc[i] || s_ovf !== exp_tc[i]) begin
        $display("FAIL saturate[%0d] out=%0d tc=%b ovf=%b expected %0d %b %b",
                 i, s_out, s_tc, s_ovf, exp_out[i], exp_tc[i], exp_tc[i]);
        n_fail++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_clamp;
    do_reset();
    limit = 4'd9; load = 1'b1; load_val = 4'd12; en = 1'b1; up_dn = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if (w_out !== 4'd9 || w_tc !== 1'b0) begin
      $display("FAIL load_clamp out=%0d tc=%b expected 9 0", w_out, w_tc);
      n_fail++;
    end
    limit = 4'd5; up_dn = 1'b0;
    tick();
    n_checks++;
    if (w_out !== 4'd5 || w_tc !== 1'b0 || w_ovf !== 1'b0) begin
      $display("FAIL limit_lowered out=%0d tc=%b ovf=%b expected 5 0 0", w_out, w_tc, w_ovf);
      n_fail++;
    end
    tick();
    n_checks++;
    if (w_out !== 4'd4 || w_tc !== 1'b0) begin
      $display("FAIL down_after_clamp out=%0d tc=%b expected 4 0", w_out, w_tc);
      n_fail++;
    end
    en = 1'b0;
  endtask

  task automatic test_prescale;
    logic       en_seq  [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp_out [11] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};
    do_reset();
    limit = 4'd15; up_dn = 1'b1;
    for (int i = 0; i < 11; i++) begin
      en = en_seq[i];
      tick();
      n_checks++;
      if (p_out !== exp_out[i] || p_tc !== 1'b0) begin
        $display("FAIL prescale[%0d] out=%0d tc=%b expected %0d 0", i, p_out, p_tc, exp_out[i]);
        n_fail++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_ovf_clear;
    do_reset();
    limit = 4'd9; load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1; clr_ovf = 1'b1;
    tick();
    n_checks++;
    if (w_out !== 4'd0 || w_tc !== 1'b1 || w_ovf !== 1'b1) begin
      $display("FAIL ovf_set_wins out=%0d tc=%b ovf=%b expected 0 1 1", w_out, w_tc, w_ovf);
      n_fail++;
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (w_ovf !== 1'b0 || w_tc !== 1'b0) begin
      $display("FAIL ovf_clear ovf=%b tc=%b expected 0 0", w_ovf, w_tc);
      n_fail++;
    end
    clr_ovf = 1'b0;
    // wrap again to set ovf, then count up to 6 and reset mid-count
    load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (w_out !== 4'd6 || w_ovf !== 1'b1) begin
      $display("FAIL pre_reset_count out=%0d ovf=%b expected 6 1", w_out, w_ovf);
      n_fail++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; en = 1'b0;
    n_checks++;
    if (w_out !== 4'd0 || w_tc !== 1'b0 || w_ovf !== 1'b0) begin
      $display("FAIL mid_reset out=%0d tc=%b ovf=%b expected 0 0 0", w_out, w_tc, w_ovf);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    limit = 4'd0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = i[0];
      tick();
      n_checks++;
      if (w_out !== 4'd0 || w_tc !== 1'b1 || s_out !== 4'd0 || s_tc !== 1'b1) begin
        $display("FAIL limit0[%0d] w_out=%0d w_tc=%b s_out=%0d s_tc=%b expected 0 1 0 1",
                 i, w_out, w_tc, s_out, s_tc);
        n_fail++;
      end
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (w_tc !== 1'b0 || w_ovf !== 1'b1) begin
      $display("FAIL limit0_idle tc=%b ovf=%b expected 0 1", w_tc, w_ovf);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_load_down();
    test_saturate();
    test_load_clamp();
    test_prescale();
    test_ovf_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
